expr_result_misr: RTL
=====================

// Module: expr_result_misr
// PURPOSE
//  Downstream consumer of the 90-bit packed result bus {y0..y17} from an expression_NNNNN block.
//  Accepts one result beat per valid/ready handshake and compresses a run of beats into a MISR signature.
//  After a programmed beat count it folds the signature to 32 bits and compares it against an expected value.
//  Gives regression a single pass/fail plus a signature per run.
// PARAMETERS
//  DATA_W   90                  width of the result bus; equals the sum of y0..y17 widths
//  SIG_POLY 90'h...0000_0000_0041  MISR feedback taps, DATA_W bits, applied when sig[DATA_W-1]=1
//  CNT_W    16                  beat-counter width
// PORTS
//  clk           in   1        single clock, rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  start         in   1        pulse: clear signature and counter, load num_beats, enter RUN
//  num_beats     in   CNT_W    beats per run, sampled on start; 0 means finish immediately
//  exp_sig       in   32       expected folded signature, sampled on start
//  in_valid      in   1        result beat present
//  in_ready      out  1        block accepts a beat this cycle
//  in_data       in   DATA_W   packed result {y0,...,y17}, y0 in the MSBs
//  done          out  1        run complete; held until next start
//  sig_out       out  32       folded signature, valid while done=1
//  pass          out  1        done and (sig_out == exp_sig)
//  beat_cnt      out  CNT_W    beats accepted in the current or last run
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, sig=0, beat_cnt=0, in_ready=0, done=0, pass=0, sig_out=0.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=0. On start -> RUN (or DONE if num_beats==0).
//   RUN: in_ready=1. Beat accepted when in_valid and in_ready:
//     sig <= {sig[DATA_W-2:0],1'b0} ^ (sig[DATA_W-1] ? SIG_POLY : 0) ^ in_data;
//     beat_cnt <= beat_cnt+1. On the accept that makes beat_cnt==num_beats -> DONE next cycle.
//   DONE: in_ready=0, done=1. sig_out=XOR of the 32-bit chunks of sig, zero-extended to 96 bits:
//     sig[31:0] ^ sig[63:32] ^ {6'b0,sig[89:64]}. pass=(sig_out==exp_sig). Registered 1 cycle after
//     the final accept. Stays in DONE until start.
//  Latency: final beat accepted in cycle N -> done=1, sig_out and pass valid in cycle N+1.
//  start in any state (including RUN mid-run) has priority over a concurrent beat. The beat is dropped,
//   sig and beat_cnt clear to 0, done/pass drop the next cycle, and the new num_beats/exp_sig are latched.
//  in_valid with in_ready=0 is ignored; in_data need not be held stable when in_valid=0.
//  beat_cnt does not wrap: num_beats saturates at 2^CNT_W-1, so the counter never overflows.
//  Async reset mid-run discards all state. No partial signature is exposed.
//  All arithmetic is unsigned. The signedness of y3/y4/y5 fields plays no part; the bus is treated as raw bits.
// STRUCTURE
//  Shared package expr_hammer_pkg holds: RESULT_W=90, localparams for field offsets of y0..y17,
//   the state enum {IDLE,RUN,DONE}, and the default SIG_POLY constant.
//  One natural sub-module: expr_misr_step (combinational next-signature function, DATA_W/POLY params).
//   It is reused by the upstream stimulus LFSR.
//  Fold and compare logic stays inline; the FSM and counters stay in this module.
// TESTING
//  T1: start, num_beats=1, one beat in_data=90'h1 -> done next cycle, sig_out=32'h1, beat_cnt=1.
//  T2: num_beats=2, beats 90'h1 then 90'h0 -> sig=90'h2, sig_out=32'h2; with exp_sig=2 -> pass=1, else 0.
//  T3: sig MSB feedback: beat1=1<<89, beat2=0 -> sig=SIG_POLY, sig_out=fold(SIG_POLY).
//  T4: num_beats=0 -> done=1 one cycle after start, sig_out=0, in_ready never asserts.
//  T5: in_valid toggling 1,0,1,0 with num_beats=2 -> only 2 accepts counted; done after second accept.
//  T6: start asserted mid-run (beat_cnt=3 of 8) with in_valid=1 -> beat dropped, beat_cnt=0, done=0;
//   a fresh run completes normally. rst_n pulse mid-run -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/expr_hammer_pkg.sv
// expr_hammer_pkg: shared result-bus geometry, MISR polynomial and FSM state codes
// Contents: RESULT_W, y0..y17 field geometry (y0 in the MSBs), default SIG_POLY, ST_* state constants.
package expr_hammer_pkg;

    localparam int RESULT_W = 90;
    localparam int Y_N      = 18;
    localparam int Y_W      = RESULT_W / Y_N;

    localparam logic [RESULT_W-1:0] SIG_POLY = 90'h41;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // LSB offset of field y<i>; y0 occupies the top bits of the bus
    function automatic int y_lsb(input int i);
        return RESULT_W - Y_W * (i + 1);
    endfunction

endpackage

// File: rtl/expr_result_misr_if.sv
// expr_result_misr_if: valid/ready result-beat channel feeding the MISR
// Signals: in_valid (beat present), in_ready (beat accepted this cycle), in_data (packed {y0..y17}).
// Modports: master drives valid/data, slave drives ready.
interface expr_result_misr_if #(
    parameter int DATA_W = expr_hammer_pkg::RESULT_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/expr_misr_step.sv
// expr_misr_step: combinational next-state of a Galois-style MISR absorbing one data word
// Ports: sig_i (current signature), data_i (word to absorb), sig_o (next signature).
module expr_misr_step #(
    parameter int                DATA_W = expr_hammer_pkg::RESULT_W,
    parameter logic [DATA_W-1:0] POLY   = expr_hammer_pkg::SIG_POLY
) (
    input  logic [DATA_W-1:0] sig_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] sig_o
);

    assign sig_o = {sig_i[DATA_W-2:0], 1'b0} ^ (sig_i[DATA_W-1] ? POLY : '0) ^ data_i;

endmodule

// File: rtl/expr_result_misr.sv
// expr_result_misr: compresses a run of result beats into a MISR signature and checks its 32-bit fold
// Ports: clk, rst_n (async, active-low); start pulse with num_beats/exp_sig sampled on it;
//        bus (slave side of the valid/ready result channel); done, sig_out, pass, beat_cnt status.
module expr_result_misr #(
    parameter int                DATA_W   = expr_hammer_pkg::RESULT_W,
    parameter logic [DATA_W-1:0] SIG_POLY = expr_hammer_pkg::SIG_POLY,
    parameter int                CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         num_beats,
    input  logic [31:0]              exp_sig,
    expr_result_misr_if.slave        bus,
    output logic                     done,
    output logic [31:0]              sig_out,
    output logic                     pass,
    output logic [CNT_W-1:0]         beat_cnt
);
    import expr_hammer_pkg::*;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] sig_q, sig_d, sig_step;
    logic [CNT_W-1:0]  cnt_q, cnt_d, nb_q, nb_d;
    logic [31:0]       exp_q, exp_d, fold;
    logic [95:0]       sig_ext;

    expr_misr_step #(.DATA_W(DATA_W), .POLY(SIG_POLY)) u_step (
        .sig_i  (sig_q),
        .data_i (bus.in_data),
        .sig_o  (sig_step)
    );

    assign bus.in_ready = state_q == ST_RUN;

    // signature zero-extended to three 32-bit chunks, then XOR-folded
    assign sig_ext  = 96'(sig_q);
    assign fold     = sig_ext[31:0] ^ sig_ext[63:32] ^ sig_ext[95:64];
    assign done     = state_q == ST_DONE;
    assign sig_out  = done ? fold : '0;
    assign pass     = done && (fold == exp_q);
    assign beat_cnt = cnt_q;

    // start wins over a concurrent beat, so an in-flight beat is dropped on restart
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        nb_d    = nb_q;
        exp_d   = exp_q;
        if (start) begin
            state_d = (num_beats == '0) ? ST_DONE : ST_RUN;
            sig_d   = '0;
            cnt_d   = '0;
            nb_d    = num_beats;
            exp_d   = exp_sig;
        end else if (bus.in_ready && bus.in_valid) begin
            sig_d   = sig_step;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q + 1'b1 == nb_q) ? ST_DONE : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            nb_q    <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            nb_q    <= nb_d;
            exp_q   <= exp_d;
        end
    end

endmodule
